// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step sequencer issuing CPU clock-enable pulses
// Optional PC breakpoint is built when CPU_RUN_BRKPT_EN is defined.
module cpu_run_ctrl #(
    parameter int         PC_W    = 32,
    parameter int         RUN_DIV = 4,
    parameter logic [7:0] IN_ADDR = 8'h08
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step,
    input  logic            cont,
    input  logic            brk_set,
    input  logic            brk_clr,
    input  logic [PC_W-1:0] brk_pc,
    input  logic [PC_W-1:0] pc,
    input  logic            io_rd,
    input  logic [7:0]      io_addr,
    input  logic            in_vld,
    output logic            in_ack,
    output logic            cpu_en,
    output logic            pause,
    output logic            brk_hit,
    output logic [1:0]      state
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [1:0] {
        S_PAUSE   = 2'd0,
        S_STEP    = 2'd1,
        S_RUN     = 2'd2,
        S_WAIT_IN = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic       ret_run_q, ret_run_d;
    logic       skip_brk_q, skip_brk_d;
    logic       cpu_en_q, cpu_en_d;
    logic       in_ack_q, in_ack_d;
    logic       brk_hit_d;
    logic       pause_q;
    logic       in_sel, blocked, div_last, bp_match;

    assign in_sel   = io_rd && (io_addr == IN_ADDR);
    assign blocked  = in_sel && !in_vld;
    assign div_last = (div_cnt_q == DIV_W'(RUN_DIV - 1));

`ifdef CPU_RUN_BRKPT_EN
    logic [PC_W-1:0] brk_addr_q;
    logic            brk_armed_q;
    logic            brk_hit_q;

    assign bp_match = brk_armed_q && (pc == brk_addr_q);
    assign brk_hit  = brk_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_armed_q <= 1'b0;
            brk_addr_q  <= '0;
            brk_hit_q   <= 1'b0;
        end else begin
            brk_hit_q <= brk_hit_d;
            if (brk_set) begin
                brk_armed_q <= 1'b1;
                brk_addr_q  <= brk_pc;
            end else if (brk_clr) begin
                brk_armed_q <= 1'b0;
            end
        end
    end
`else
    logic brk_unused;

    assign bp_match   = 1'b0;
    assign brk_hit    = 1'b0;
    assign brk_unused = ^{brk_set, brk_clr, brk_pc, brk_hit_d};
`endif

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        ret_run_d  = ret_run_q;
        skip_brk_d = skip_brk_q;
        cpu_en_d   = 1'b0;
        in_ack_d   = 1'b0;
        brk_hit_d  = 1'b0;
        case (state_q)
            S_PAUSE: begin
                if (cont) begin
                    state_d    = S_RUN;
                    div_cnt_d  = '0;
                    skip_brk_d = 1'b1;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (blocked) begin
                    state_d   = S_WAIT_IN;
                    ret_run_d = 1'b0;
                end else begin
                    cpu_en_d = 1'b1;
                    in_ack_d = in_sel;
                    state_d  = S_PAUSE;
                end
            end
            S_RUN: begin
                if (cont) begin
                    state_d = S_PAUSE;
                end else begin
                    div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);
                    if (div_last) begin
                        // skip_brk lets a run started on the breakpoint PC get past it
                        if (bp_match && !skip_brk_q) begin
                            brk_hit_d = 1'b1;
                            state_d   = S_PAUSE;
                        end else if (blocked) begin
                            state_d   = S_WAIT_IN;
                            ret_run_d = 1'b1;
                        end else begin
                            cpu_en_d   = 1'b1;
                            in_ack_d   = in_sel;
                            skip_brk_d = 1'b0;
                        end
                    end
                end
            end
            S_WAIT_IN: begin
                if (cont) begin
                    state_d = S_PAUSE;
                end else if (in_vld) begin
                    cpu_en_d = 1'b1;
                    in_ack_d = 1'b1;
                    if (ret_run_q) begin
                        state_d    = S_RUN;
                        div_cnt_d  = '0;
                        skip_brk_d = 1'b0;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
            end
            default: state_d = S_PAUSE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_PAUSE;
            div_cnt_q  <= '0;
            ret_run_q  <= 1'b0;
            skip_brk_q <= 1'b0;
            cpu_en_q   <= 1'b0;
            in_ack_q   <= 1'b0;
            pause_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            ret_run_q  <= ret_run_d;
            skip_brk_q <= skip_brk_d;
            cpu_en_q   <= cpu_en_d;
            in_ack_q   <= in_ack_d;
            pause_q    <= (state_d == S_PAUSE);
        end
    end

    assign cpu_en = cpu_en_q;
    assign in_ack = in_ack_q;
    assign pause  = pause_q;
    assign state  = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int RUN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0, cont = 1'b0, brk_set = 1'b0, brk_clr = 1'b0;
    logic [31:0] brk_pc = '0, pc = '0;
    logic        io_rd = 1'b0, in_vld = 1'b0;
    logic [7:0]  io_addr = '0;
    logic        in_ack, cpu_en, pause, brk_hit;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;
    bit follow = 0;

    // reference model state
    int m_st, m_t;
    bit m_ret, m_skip, m_armed;
    logic [31:0] m_addr;
    bit e_en, e_ack, e_hit;

    cpu_run_ctrl #(.PC_W(32), .RUN_DIV(RUN_DIV), .IN_ADDR(8'h08)) dut (
        .clk(clk), .rst(rst), .step(step), .cont(cont), .brk_set(brk_set),
        .brk_clr(brk_clr), .brk_pc(brk_pc), .pc(pc), .io_rd(io_rd),
        .io_addr(io_addr), .in_vld(in_vld), .in_ack(in_ack), .cpu_en(cpu_en),
        .pause(pause), .brk_hit(brk_hit), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (follow && cpu_en) pc = pc + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total += 5;
        if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        if (pause !== 1'b1) begin bad++; $display("FAIL reset_pause got=%0b want=1", pause); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en got=%0b want=0", cpu_en); end
        if (in_ack !== 1'b0) begin bad++; $display("FAIL reset_in_ack got=%0b want=0", in_ack); end
        if (brk_hit !== 1'b0) begin bad++; $display("FAIL reset_brk_hit got=%0b want=0", brk_hit); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_step();
        int pulses = 0;
        step = 1'b1;
        tick();
        step = 1'b0;
        total += 2;
        if (state !== 2'd1) begin bad++; $display("FAIL step_state1 got=%0d want=1", state); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL step_early_en got=%0b want=0", cpu_en); end
        tick();
        total += 3;
        if (cpu_en !== 1'b1) begin bad++; $display("FAIL step_en got=%0b want=1", cpu_en); end
        if (state !== 2'd0) begin bad++; $display("FAIL step_state_end got=%0d want=0", state); end
        if (pause !== 1'b1) begin bad++; $display("FAIL step_pause got=%0b want=1", pause); end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_en) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL step_extra_en got=%0d want=0", pulses); end
    endtask

    task automatic test_run();
        int pulses = 0;
        int wrong = 0;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        for (int k = 1; k < 40; k++) begin
            tick();
            if (cpu_en) pulses++;
            if (cpu_en !== ((k % RUN_DIV) == 0)) wrong++;
            if (state !== 2'd2) wrong++;
        end
        total += 2;
        if (wrong != 0) begin bad++; $display("FAIL run_spacing got=%0d want=0 errors", wrong); end
        if (pulses != 9) begin bad++; $display("FAIL run_count got=%0d want=9", pulses); end
        cont = 1'b1;
        tick();
        cont = 1'b0;
        total += 2;
        if (state !== 2'd0) begin bad++; $display("FAIL run_stop_state got=%0d want=0", state); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_stop_en got=%0b want=0", cpu_en); end
    endtask

    task automatic test_breakpoint();
        int pulses = 0;
        bit hit = 0;
        bit hit_again = 0;
        bit got = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pc = 32'h0;
        follow = 1;
        brk_pc = 32'h0C;
        brk_set = 1'b1;
        tick();
        brk_set = 1'b0;
        cont = 1'b1;
        tick();
        cont = 1'b0;
`ifdef CPU_RUN_BRKPT_EN
        for (int k = 0; k < 100 && !hit; k++) begin
            tick();
            if (cpu_en) pulses++;
            if (brk_hit) hit = 1;
        end
        total += 5;
        if (!hit) begin bad++; $display("FAIL brk_hit_seen got=0 want=1"); end
        if (pc !== 32'h0C) begin bad++; $display("FAIL brk_stop_pc got=%h want=0c", pc); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL brk_no_en got=%0b want=0", cpu_en); end
        if (state !== 2'd0) begin bad++; $display("FAIL brk_state got=%0d want=0", state); end
        if (pulses != 3) begin bad++; $display("FAIL brk_pulses got=%0d want=3", pulses); end
        tick();
        total++;
        if (brk_hit !== 1'b0) begin bad++; $display("FAIL brk_hit_width got=%0b want=0", brk_hit); end
        cont = 1'b1;
        tick();
        cont = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (brk_hit) hit_again = 1;
            if (cpu_en) got = 1;
        end
        total += 3;
        if (!got) begin bad++; $display("FAIL brk_resume_en got=0 want=1"); end
        if (pc !== 32'h10) begin bad++; $display("FAIL brk_resume_pc got=%h want=10", pc); end
        if (hit_again) begin bad++; $display("FAIL brk_resume_rehit got=1 want=0"); end
`else
        for (int k = 0; k < 30; k++) begin
            tick();
            if (brk_hit) hit = 1;
        end
        total += 3;
        if (hit) begin bad++; $display("FAIL brk_disabled_hit got=1 want=0"); end
        if (state !== 2'd2) begin bad++; $display("FAIL brk_disabled_state got=%0d want=2", state); end
        if (pc !== 32'h1C) begin bad++; $display("FAIL brk_disabled_pc got=%h want=1c", pc); end
`endif
        cont = 1'b1;
        tick();
        cont = 1'b0;
        follow = 0;
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL brk_end_state got=%0d want=0", state); end
    endtask

    task automatic test_in_wait();
        int wrong = 0;
        io_rd = 1'b1;
        io_addr = 8'h08;
        in_vld = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        total++;
        if (state !== 2'd3) begin bad++; $display("FAIL wait_state got=%0d want=3", state); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cpu_en !== 1'b0 || in_ack !== 1'b0 || state !== 2'd3) wrong++;
        end
        total++;
        if (wrong != 0) begin bad++; $display("FAIL wait_hold got=%0d want=0 errors", wrong); end
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        total += 3;
        if (cpu_en !== 1'b1) begin bad++; $display("FAIL wait_release_en got=%0b want=1", cpu_en); end
        if (in_ack !== 1'b1) begin bad++; $display("FAIL wait_release_ack got=%0b want=1", in_ack); end
        if (state !== 2'd0) begin bad++; $display("FAIL wait_release_state got=%0d want=0", state); end
        io_rd = 1'b0;
        tick();
        total++;
        if (cpu_en !== 1'b0 || in_ack !== 1'b0) begin
            bad++; $display("FAIL wait_pulse_width got=%0b%0b want=00", cpu_en, in_ack);
        end
    endtask

    task automatic test_same_cycle();
        bit hit = 0;
        cont = 1'b1;
        step = 1'b1;
        tick();
        cont = 1'b0;
        step = 1'b0;
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL cont_step_state got=%0d want=2", state); end
        cont = 1'b1;
        tick();
        cont = 1'b0;
        io_rd = 1'b1;
        io_addr = 8'h08;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        cont = 1'b1;
        in_vld = 1'b1;
        tick();
        cont = 1'b0;
        in_vld = 1'b0;
        io_rd = 1'b0;
        total += 3;
        if (state !== 2'd0) begin bad++; $display("FAIL cont_vld_state got=%0d want=0", state); end
        if (in_ack !== 1'b0) begin bad++; $display("FAIL cont_vld_ack got=%0b want=0", in_ack); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL cont_vld_en got=%0b want=0", cpu_en); end
`ifdef CPU_RUN_BRKPT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pc = 32'h0;
        follow = 1;
        brk_pc = 32'h08;
        brk_set = 1'b1;
        brk_clr = 1'b1;
        tick();
        brk_set = 1'b0;
        brk_clr = 1'b0;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            tick();
            if (brk_hit) hit = 1;
        end
        follow = 0;
        total += 2;
        if (!hit) begin bad++; $display("FAIL set_clr_armed got=0 want=1"); end
        if (pc !== 32'h08) begin bad++; $display("FAIL set_clr_pc got=%h want=08", pc); end
`endif
    endtask

    task automatic test_rst_mid();
        bit hit = 0;
        io_rd = 1'b1;
        io_addr = 8'h08;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        rst = 1'b1;
        in_vld = 1'b1;
        tick();
        rst = 1'b0;
        in_vld = 1'b0;
        io_rd = 1'b0;
        total += 4;
        if (state !== 2'd0) begin bad++; $display("FAIL rst_wait_state got=%0d want=0", state); end
        if (pause !== 1'b1) begin bad++; $display("FAIL rst_wait_pause got=%0b want=1", pause); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_wait_en got=%0b want=0", cpu_en); end
        if (in_ack !== 1'b0) begin bad++; $display("FAIL rst_wait_ack got=%0b want=0", in_ack); end
        pc = 32'h0;
        brk_pc = 32'h08;
        brk_set = 1'b1;
        tick();
        brk_set = 1'b0;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        for (int k = 1; k < RUN_DIV; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 4;
        if (state !== 2'd0) begin bad++; $display("FAIL rst_run_state got=%0d want=0", state); end
        if (pause !== 1'b1) begin bad++; $display("FAIL rst_run_pause got=%0b want=1", pause); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_run_en got=%0b want=0", cpu_en); end
        if (brk_hit !== 1'b0) begin bad++; $display("FAIL rst_run_hit got=%0b want=0", brk_hit); end
        follow = 1;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (brk_hit) hit = 1;
        end
        total++;
        if (hit) begin bad++; $display("FAIL rst_disarm got=1 want=0"); end
        cont = 1'b1;
        tick();
        cont = 1'b0;
        follow = 0;
    endtask

    // Sequencer behaviour stated as rules: run fires every RUN_DIV-th cycle since entry
    task automatic model_step();
        bit wants_in, starve, bp;
        wants_in = io_rd && (io_addr == 8'h08);
        starve = wants_in && !in_vld;
        e_en = 0;
        e_ack = 0;
        e_hit = 0;
        if (rst) begin
            m_st = 0; m_t = 0; m_ret = 0; m_skip = 0; m_armed = 0;
            return;
        end
`ifdef CPU_RUN_BRKPT_EN
        bp = m_armed && (pc == m_addr) && !m_skip;
        if (brk_set) begin m_armed = 1; m_addr = brk_pc; end
        else if (brk_clr) m_armed = 0;
`else
        bp = 0;
`endif
        if (m_st == 0) begin
            if (cont) begin m_st = 2; m_t = 0; m_skip = 1; end
            else if (step) m_st = 1;
        end else if (m_st == 1) begin
            if (starve) begin m_st = 3; m_ret = 0; end
            else begin e_en = 1; e_ack = wants_in; m_st = 0; end
        end else if (m_st == 2) begin
            if (cont) m_st = 0;
            else if ((m_t % RUN_DIV) == RUN_DIV - 1) begin
                if (bp) begin e_hit = 1; m_st = 0; end
                else if (starve) begin m_st = 3; m_ret = 1; end
                else begin e_en = 1; e_ack = wants_in; m_skip = 0; end
            end
            m_t++;
        end else begin
            if (cont) m_st = 0;
            else if (in_vld) begin
                e_en = 1;
                e_ack = 1;
                m_t = 0;
                if (m_ret) begin m_st = 2; m_skip = 0; end
                else m_st = 0;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 299) == 0);
            step = ($urandom_range(0, 5) == 0);
            cont = ($urandom_range(0, 24) == 0);
            in_vld = ($urandom_range(0, 3) == 0);
            brk_set = ($urandom_range(0, 39) == 0);
            brk_clr = ($urandom_range(0, 59) == 0);
            brk_pc = 32'($urandom_range(0, 7)) << 2;
            model_step();
            tick();
            total += 5;
            if (cpu_en !== e_en) begin bad++; $display("FAIL rnd_en cyc=%0d got=%0b want=%0b", c, cpu_en, e_en); end
            if (in_ack !== e_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%0b want=%0b", c, in_ack, e_ack); end
            if (brk_hit !== e_hit) begin bad++; $display("FAIL rnd_hit cyc=%0d got=%0b want=%0b", c, brk_hit, e_hit); end
            if (state !== 2'(m_st)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", c, state, m_st); end
            if (pause !== (m_st == 0)) begin bad++; $display("FAIL rnd_pause cyc=%0d got=%0b want=%0b", c, pause, m_st == 0); end
            if (e_en) begin
                pc = (pc + 32'd4) & 32'h1F;
                io_rd = ($urandom_range(0, 2) == 0);
                io_addr = $urandom_range(0, 1) ? 8'h08 : 8'h09;
            end
        end
        rst = 1'b0;
        step = 1'b0;
        cont = 1'b0;
        in_vld = 1'b0;
        brk_set = 1'b0;
        brk_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_breakpoint();
        test_in_wait();
        test_same_cycle();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
